// File: rtl/a2b_word.sv
// ASCII-to-binary word assembler: packs binary or hex digits MSB-first into a
// WIDTH-bit word, emitting on a full word or a CR/LF terminator.
module a2b_word #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in,
  input  logic             w_RX_dv,
  input  logic             hex_mode,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             err,
  output logic             busy,
  output logic             dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] N_BIN = CW'(WIDTH);
  localparam logic [CW-1:0] N_HEX = CW'(WIDTH / 4);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             mode_q;

  logic             eff_mode;
  logic             is_bin;
  logic             is_hex;
  logic [3:0]       nib;
  logic             is_digit;
  logic             is_term;
  logic             is_space;
  logic [WIDTH-1:0] next_acc;
  logic [CW-1:0]    cnt_inc;
  logic [CW-1:0]    n_digits;

  // The mode is taken live from hex_mode only for the first digit of a word.
  always_comb begin
    eff_mode = (state == IDLE) ? hex_mode : mode_q;
    is_bin   = (in == 8'h30) || (in == 8'h31);
    is_hex   = 1'b1;
    nib      = 4'h0;
    if (in >= 8'h30 && in <= 8'h39) begin
      nib = in[3:0];
    end else if ((in >= 8'h41 && in <= 8'h46) || (in >= 8'h61 && in <= 8'h66)) begin
      nib = in[3:0] + 4'd9;
    end else begin
      is_hex = 1'b0;
    end
    is_digit = eff_mode ? is_hex : is_bin;
    is_term  = (in == 8'h0D) || (in == 8'h0A);
    is_space = (in == 8'h20);
    n_digits = eff_mode ? N_HEX : N_BIN;
    cnt_inc  = cnt + CW'(1);
    next_acc = '0;
    if (eff_mode) begin
      next_acc = ((state == IDLE) ? '0 : (acc << 4)) | WIDTH'(nib);
    end else begin
      next_acc = ((state == IDLE) ? '0 : (acc << 1)) | WIDTH'(in[0]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      mode_q    <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      err       <= 1'b0;
      if (w_RX_dv) begin
        if (is_digit) begin
          if (state == IDLE) mode_q <= hex_mode;
          if (cnt_inc == n_digits) begin
            out       <= next_acc;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            state     <= IDLE;
          end else begin
            acc   <= next_acc;
            cnt   <= cnt_inc;
            state <= ACCUM;
          end
        end else if (is_term) begin
          if (state == ACCUM) begin
            out       <= acc;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
            state     <= IDLE;
          end
        end else if (!is_space) begin
          err   <= 1'b1;
          acc   <= '0;
          cnt   <= '0;
          state <= IDLE;
        end
      end
    end
  end

  assign busy      = (state == ACCUM);
  assign dbg_state = state;

endmodule

// File: tb/tb_a2b_word.sv
// Directed bench for a2b_word: an 8-bit and a 16-bit instance driven from
// shared character/mode lines with separate valid strobes.
module tb_a2b_word;

  logic        clk;
  logic        rst;
  logic [7:0]  in;
  logic        dv8;
  logic        dv16;
  logic        hex_mode;

  logic [7:0]  out8;
  logic        valid8;
  logic        err8;
  logic        busy8;
  logic        st8;
  logic [15:0] out16;
  logic        valid16;
  logic        err16;
  logic        busy16;
  logic        st16;

  int n_vec;
  int n_miss;

  a2b_word #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in(in), .w_RX_dv(dv8), .hex_mode(hex_mode),
    .out(out8), .out_valid(valid8), .err(err8), .busy(busy8), .dbg_state(st8)
  );

  a2b_word #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .in(in), .w_RX_dv(dv16), .hex_mode(hex_mode),
    .out(out16), .out_valid(valid16), .err(err16), .busy(busy16), .dbg_state(st16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one character to the chosen instance, then sample 1 ns after the edge.
  task automatic drv(input logic [7:0] c, input bit sel16);
    in   = c;
    dv8  = !sel16;
    dv16 = sel16;
    @(posedge clk);
    #1;
    dv8  = 1'b0;
    dv16 = 1'b0;
  endtask

  task automatic idle();
    dv8  = 1'b0;
    dv16 = 1'b0;
    in   = 8'hxx;
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic v, input logic [7:0] o,
                      input logic e, input logic b);
    check({tag, ".valid"}, 64'(valid8), 64'(v));
    check({tag, ".out"},   64'(out8),   64'(o));
    check({tag, ".err"},   64'(err8),   64'(e));
    check({tag, ".busy"},  64'(busy8),  64'(b));
  endtask

  task automatic chk16(input string tag, input logic v, input logic [15:0] o,
                       input logic e, input logic b);
    check({tag, ".valid"}, 64'(valid16), 64'(v));
    check({tag, ".out"},   64'(out16),   64'(o));
    check({tag, ".err"},   64'(err16),   64'(e));
    check({tag, ".busy"},  64'(busy16),  64'(b));
  endtask

  task automatic feed8(input string s);
    for (int i = 0; i < s.len(); i++) drv(s[i], 1'b0);
  endtask

  initial begin
    string bits;
    n_vec    = 0;
    n_miss   = 0;
    rst      = 1'b0;
    in       = 8'h00;
    dv8      = 1'b0;
    dv16     = 1'b0;
    hex_mode = 1'b0;
    #1;
    chk8("reset8", 1'b0, 8'h00, 1'b0, 1'b0);
    chk16("reset16", 1'b0, 16'h0000, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Binary 8-bit word "00110001"
    bits = "00110001";
    for (int i = 0; i < 8; i++) begin
      drv(bits[i], 1'b0);
      if (i < 7) chk8($sformatf("bin8_c%0d", i + 1), 1'b0, 8'h00, 1'b0, 1'b1);
    end
    chk8("bin8_emit", 1'b1, 8'h31, 1'b0, 1'b0);
    check("bin8_state", 64'(st8), 64'(0));
    idle();
    chk8("bin8_after", 1'b0, 8'h31, 1'b0, 1'b0);

    // Hex back-to-back "a5" then "3C"
    hex_mode = 1'b1;
    drv("a", 1'b0);
    chk8("hex_a", 1'b0, 8'h31, 1'b0, 1'b1);
    drv("5", 1'b0);
    chk8("hex_a5", 1'b1, 8'hA5, 1'b0, 1'b0);
    drv("3", 1'b0);
    chk8("hex_3", 1'b0, 8'hA5, 1'b0, 1'b1);
    drv("C", 1'b0);
    chk8("hex_3C", 1'b1, 8'h3C, 1'b0, 1'b0);
    idle();

    // 16-bit binary "10 1" + CR; the space is skipped
    hex_mode = 1'b0;
    drv("1", 1'b1);
    drv("0", 1'b1);
    drv(" ", 1'b1);
    chk16("bin16_space", 1'b0, 16'h0000, 1'b0, 1'b1);
    drv("1", 1'b1);
    drv(8'h0D, 1'b1);
    chk16("bin16_cr", 1'b1, 16'h0005, 1'b0, 1'b0);
    drv(8'h0A, 1'b1);
    chk16("bin16_lf_idle", 1'b0, 16'h0005, 1'b0, 1'b0);

    // 16-bit hex full word
    hex_mode = 1'b1;
    drv("B", 1'b1);
    drv("e", 1'b1);
    drv("E", 1'b1);
    chk16("hex16_3", 1'b0, 16'h0005, 1'b0, 1'b1);
    drv("f", 1'b1);
    chk16("hex16_full", 1'b1, 16'hBEEF, 1'b0, 1'b0);

    // Illegal characters discard the partial word
    hex_mode = 1'b0;
    feed8("10");
    drv("x", 1'b0);
    chk8("err_x", 1'b0, 8'h3C, 1'b1, 1'b0);
    idle();
    chk8("err_clear", 1'b0, 8'h3C, 1'b0, 1'b0);
    drv("1", 1'b0);
    drv("2", 1'b0);
    chk8("err_2bin", 1'b0, 8'h3C, 1'b1, 1'b0);
    feed8("11111111");
    chk8("ones", 1'b1, 8'hFF, 1'b0, 1'b0);

    // Mode is latched at the first digit of a word
    hex_mode = 1'b1;
    drv("7", 1'b0);
    hex_mode = 1'b0;
    drv("F", 1'b0);
    chk8("latch_7F", 1'b1, 8'h7F, 1'b0, 1'b0);
    drv("A", 1'b0);
    chk8("latch_next_bin", 1'b0, 8'h7F, 1'b1, 1'b0);

    // Asynchronous reset mid-word
    feed8("1010");
    chk8("pre_reset", 1'b0, 8'h7F, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk8("async_reset", 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    feed8("1111000");
    chk8("post_reset_7", 1'b0, 8'h00, 1'b0, 1'b1);
    drv("0", 1'b0);
    chk8("post_reset_F0", 1'b1, 8'hF0, 1'b0, 1'b0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
